// File: rtl/latch_wr_ctrl.sv
// Round-robin write sequencer for a latch bank (SETUP, OPEN x EN_CYCLES, HOLD, ACK); one write per EN_CYCLES+4 clocks.
// Requests are level-held until ack; optional HOLD-phase readback check under LATCH_CTRL_READBACK_EN.
module latch_wr_ctrl #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int DEPTH     = 4,
  parameter int EN_CYCLES = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*W-1:0]     wdata,
  input  logic [N*AW-1:0]    waddr,
  output logic [N-1:0]       ack,
  output logic [W-1:0]       lat_d,
  output logic [DEPTH-1:0]   lat_en,
  input  logic [DEPTH*W-1:0] lat_q,
  output logic               busy,
  output logic               err
);

  localparam int PW = $clog2(N);
  localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    ACK   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    gnt_q, gnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     lat_d_d;
  logic [DEPTH-1:0] lat_en_d;
  logic [N-1:0]     ack_d;

  logic             found;
  logic [PW-1:0]    sel;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr_q) + k) % N]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr_q) + k) % N);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    lat_d_d = lat_d;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SETUP;
          gnt_d   = sel;
          ptr_d   = (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
          addr_d  = waddr[sel*AW +: AW];
          lat_d_d = wdata[sel*W +: W];
        end
      end
      SETUP: begin
        state_d = OPEN;
        cnt_d   = '0;
      end
      OPEN: begin
        if (cnt_q == CW'(EN_CYCLES - 1)) state_d = HOLD;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      HOLD:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    lat_en_d = '0;
    if (state_d == OPEN) lat_en_d[addr_d] = 1'b1;
    ack_d = '0;
    if (state_d == ACK) ack_d[gnt_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      lat_d   <= '0;
      lat_en  <= '0;
      ack     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      lat_d   <= lat_d_d;
      lat_en  <= lat_en_d;
      ack     <= ack_d;
    end
  end

  assign busy = (state_q != IDLE);

`ifdef LATCH_CTRL_READBACK_EN
  logic err_q;

  // The latch has been closed for a full cycle in HOLD, so its output is settled.
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (state_q == HOLD && lat_q[addr_q*W +: W] != lat_d)
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_lat_q;
  assign unused_lat_q = ^lat_q;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_latch_wr_ctrl.sv
// Scoreboard bench for latch_wr_ctrl: stimulus pushes expected writes, a negedge monitor checks each ack.
// A behavioural latch bank (with optional stuck bit) drives lat_q.
module tb_latch_wr_ctrl;
  localparam int N = 4, W = 8, DEPTH = 4, AW = 2, EN_CYCLES = 2;
`ifdef LATCH_CTRL_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  typedef struct {
    int gnt;
    int addr;
    int data;
    int mem;
    int err;
  } item_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       req = '0;
  logic [N*W-1:0]     wdata = '0;
  logic [N*AW-1:0]    waddr = '0;
  logic [N-1:0]       ack;
  logic [W-1:0]       lat_d;
  logic [DEPTH-1:0]   lat_en;
  logic [DEPTH*W-1:0] lat_q;
  logic               busy;
  logic               err;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] stuck_mask = '0;
  logic         auto_clr = 1'b1;

  item_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0, gnt_cyc = 0, en_first = 0, en_cnt = 0, en_bad = 0;
  logic busy_prev = 1'b0;

  latch_wr_ctrl #(.N(N), .W(W), .DEPTH(DEPTH), .EN_CYCLES(EN_CYCLES)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .waddr(waddr),
    .ack(ack), .lat_d(lat_d), .lat_en(lat_en), .lat_q(lat_q),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

  always @(negedge clk)
    for (int i = 0; i < DEPTH; i++)
      if (lat_en[i]) mem[i] = lat_d & ~stuck_mask;

  always_comb begin
    lat_q = '0;
    for (int i = 0; i < DEPTH; i++) lat_q[i*W +: W] = mem[i];
  end

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: tracks grant/enable timing and checks every ack against the scoreboard.
  always @(negedge clk) begin
    item_t e;
    cyc++;
    if (rst) begin
      busy_prev = 1'b0;
      en_cnt    = 0;
      en_bad    = 0;
      if (ack != '0) chk("ack_in_reset", int'(ack), 0);
    end else begin
      if (busy && !busy_prev) begin
        gnt_cyc  = cyc;
        en_cnt   = 0;
        en_bad   = 0;
        en_first = 0;
      end
      busy_prev = busy;
      if (lat_en != '0) begin
        if (en_cnt == 0) en_first = cyc;
        en_cnt++;
        if (exp_q.size() == 0 || int'(lat_en) != (1 << exp_q[0].addr)) en_bad = 1;
      end
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", int'(ack), 0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_vector", int'(ack), 1 << e.gnt);
          chk("lat_d_held", int'(lat_d), e.data);
          chk("latch_word", int'(mem[e.addr]), e.mem);
          chk("en_cycles", en_cnt, EN_CYCLES);
          chk("en_onehot_addr", en_bad, 0);
          chk("en_rise_delay", en_first - gnt_cyc, 1);
          chk("ack_latency", cyc - gnt_cyc, EN_CYCLES + 2);
          chk("err_at_ack", int'(err), e.err);
        end
      end
    end
  end

  task automatic set_wr(int i, int addr, int data);
    waddr[i*AW +: AW] = AW'(addr);
    wdata[i*W +: W]   = W'(data);
  endtask

  task automatic push(int gnt, int addr, int data, int memv, int e);
    item_t it;
    it.gnt = gnt; it.addr = addr; it.data = data; it.mem = memv; it.err = e;
    exp_q.push_back(it);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    int done = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (auto_clr) req = req & ~ack;
      if (exp_q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    chk(name, done, 1);
  endtask

  initial begin
    int seen;
    // Reset values
    do_reset();
    chk("rst_ack", int'(ack), 0);
    chk("rst_lat_en", int'(lat_en), 0);
    chk("rst_lat_d", int'(lat_d), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);

    // Single write
    set_wr(1, 2, 8'hA5);
    push(1, 2, 8'hA5, 8'hA5, 0);
    auto_clr = 1'b1;
    req = 4'b0010;
    wait_done("single_done", 40);
    chk("single_word", int'(mem[2]), 8'hA5);

    // Round robin with persistent requests
    do_reset();
    for (int i = 0; i < N; i++) set_wr(i, 3 - i, 8'h30 + i);
    push(0, 3, 8'h30, 8'h30, 0);
    push(1, 2, 8'h31, 8'h31, 0);
    push(2, 1, 8'h32, 8'h32, 0);
    push(3, 0, 8'h33, 8'h33, 0);
    push(0, 3, 8'h30, 8'h30, 0);
    auto_clr = 1'b0;
    req = 4'b1111;
    wait_done("rr_done", 80);
    req = '0;
    auto_clr = 1'b1;

    // Early drop: requester 3 lowers req the cycle after grant
    set_wr(3, 1, 8'h5A);
    push(3, 1, 8'h5A, 8'h5A, 0);
    req = 4'b1000;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) begin seen = 1; break; end
    end
    chk("drop_grant_seen", seen, 1);
    req = '0;
    wait_done("drop_done", 40);
    repeat (8) @(negedge clk);
    chk("drop_word", int'(mem[1]), 8'h5A);

    // Reset mid-OPEN: no ack may follow
    set_wr(1, 3, 8'h77);
    req = 4'b0010;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (lat_en != '0) begin seen = 1; break; end
    end
    chk("open_seen", seen, 1);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    chk("midrst_lat_en", int'(lat_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ack", int'(ack), 0);
    chk("midrst_lat_d", int'(lat_d), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    // Pointer must be back at 0: requester 0 wins over 2
    set_wr(0, 3, 8'hC3);
    set_wr(2, 0, 8'h3C);
    push(0, 3, 8'hC3, 8'hC3, 0);
    push(2, 0, 8'h3C, 8'h3C, 0);
    req = 4'b0101;
    wait_done("post_rst_done", 60);

    // Readback with bit 0 stuck low
    stuck_mask = 8'h01;
    set_wr(0, 2, 8'h01);
    push(0, 2, 8'h01, 8'h00, RB);
    req = 4'b0001;
    wait_done("rb_done", 40);
    repeat (5) @(negedge clk);
    chk("err_sticky", int'(err), RB);
    stuck_mask = '0;
    do_reset();
    chk("err_cleared", int'(err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

endmodule
